// File: rtl/fetch_exec_sequencer.sv
// fetch_exec_sequencer
//   Walks the SAP-2 datapath through opcode/operand fetch, a bounded execute
//   window for the per-opcode microcode, and HALT.
//   Each byte fetch is four cycles: F_ADDR -> F_READ -> F_LATCH -> F_INC.
// Ports
//   clk, reset        : rising-edge clock, asynchronous active-low reset
//   instr_len_i       : byte count of the latched opcode (from decoder)
//   exec_steps_i      : execute cycles needed by the latched opcode
//   is_halt_i         : latched opcode is HLT
//   load_mar_pc_o, mem_read_o, load_ir_o, load_temp1_o, load_temp2_o,
//   pc_inc_o          : one-hot datapath strobes (Moore decodes)
//   exec_valid_o      : execute window active
//   exec_step_o       : 0-based execute step
//   halted_o          : sequencer in HALT
//   state_o           : encoded state for debug
module fetch_exec_sequencer #(
  parameter int MAX_BYTES   = 3,
  parameter int EXEC_STEP_W = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             instr_len_i,
  input  logic [EXEC_STEP_W-1:0] exec_steps_i,
  input  logic                   is_halt_i,
  output logic                   load_mar_pc_o,
  output logic                   mem_read_o,
  output logic                   load_ir_o,
  output logic                   load_temp1_o,
  output logic                   load_temp2_o,
  output logic                   pc_inc_o,
  output logic                   exec_valid_o,
  output logic [EXEC_STEP_W-1:0] exec_step_o,
  output logic                   halted_o,
  output logic [2:0]             state_o
);

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    F_ADDR  = 3'd1,
    F_READ  = 3'd2,
    F_LATCH = 3'd3,
    F_INC   = 3'd4,
    EXEC    = 3'd5,
    HALT    = 3'd6
  } state_e;

  state_e                 state_q, state_d;
  logic [1:0]             byte_idx_q, byte_idx_d;
  logic [1:0]             len_q, len_d;
  logic [EXEC_STEP_W-1:0] step_q, step_d;
  logic [EXEC_STEP_W-1:0] last_q, last_d;   // terminal step N-1

  logic [1:0] len_clamped;
  logic [1:0] len_cur;
  logic       byte0;
  logic       more_bytes;

  // A zero length still means the opcode byte itself was fetched.
  always_comb begin
    len_clamped = instr_len_i;
    if (instr_len_i == 2'd0)
      len_clamped = 2'd1;
    else if (int'(instr_len_i) > MAX_BYTES)
      len_clamped = 2'(MAX_BYTES);
  end

  // On byte 0 the length is being sampled this very cycle, so the exit
  // decision uses the live (clamped) decoder value instead of len_q.
  assign byte0      = (byte_idx_q == 2'd0);
  assign len_cur    = byte0 ? len_clamped : len_q;
  assign more_bytes = ({1'b0, byte_idx_q} + 3'd1) < {1'b0, len_cur};

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    len_d      = len_q;
    step_d     = step_q;
    last_d     = last_q;
    case (state_q)
      S_RESET: state_d = F_ADDR;
      F_ADDR:  state_d = F_READ;
      F_READ:  state_d = F_LATCH;
      F_LATCH: state_d = F_INC;
      F_INC: begin
        byte_idx_d = byte_idx_q + 2'd1;
        if (byte0) len_d = len_clamped;
        if (byte0 && is_halt_i) begin
          state_d = HALT;
        end else if (more_bytes) begin
          state_d = F_ADDR;
        end else begin
          state_d = EXEC;
          step_d  = '0;
          last_d  = (exec_steps_i == '0) ? '0 : exec_steps_i - 1'b1;
        end
      end
      EXEC: begin
        // Compare against N-1 so the counter never needs to wrap.
        if (step_q == last_q) begin
          state_d    = F_ADDR;
          step_d     = '0;
          byte_idx_d = 2'd0;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = S_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_RESET;
      byte_idx_q <= 2'd0;
      len_q      <= 2'd1;
      step_q     <= '0;
      last_q     <= '0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      len_q      <= len_d;
      step_q     <= step_d;
      last_q     <= last_d;
    end
  end

  assign load_mar_pc_o = (state_q == F_ADDR);
  assign mem_read_o    = (state_q == F_READ);
  assign load_ir_o     = (state_q == F_LATCH) && (byte_idx_q == 2'd0);
  assign load_temp1_o  = (state_q == F_LATCH) && (byte_idx_q == 2'd1);
  assign load_temp2_o  = (state_q == F_LATCH) && (byte_idx_q == 2'd2);
  assign pc_inc_o      = (state_q == F_INC);
  assign exec_valid_o  = (state_q == EXEC);
  assign exec_step_o   = step_q;
  assign halted_o      = (state_q == HALT);
  assign state_o       = state_q;

endmodule

// File: tb/tb_fetch_exec_sequencer.sv
// Scoreboarded bench: the stimulus plays the decoder, expands each issued
// instruction into its expected per-cycle observation trace and queues it;
// a negedge monitor pops one entry per cycle and compares.
// A second instance with MAX_BYTES=2 is fed a fixed 3-byte opcode.
module tb_fetch_exec_sequencer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] len;
  logic [2:0] steps;
  logic       halt;

  logic       mar, rd, ir, t1, t2, inc, ev, hlt;
  logic [2:0] step, st;

  logic       mar2, rd2, ir2, t12, t22, inc2, ev2, hlt2;
  logic [2:0] step2, st2;

  typedef struct packed {
    logic [2:0] st;
    logic mar, rd, ir, t1, t2, inc, ev;
    logic [2:0] step;
    logic halt;
  } obs_t;

  obs_t expq[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc_no = 0;
  int   c2 = 0;

  always #5 clk = ~clk;

  fetch_exec_sequencer #(.MAX_BYTES(3), .EXEC_STEP_W(3)) u_dut (
    .clk(clk), .reset(rst_n), .instr_len_i(len), .exec_steps_i(steps),
    .is_halt_i(halt), .load_mar_pc_o(mar), .mem_read_o(rd), .load_ir_o(ir),
    .load_temp1_o(t1), .load_temp2_o(t2), .pc_inc_o(inc),
    .exec_valid_o(ev), .exec_step_o(step), .halted_o(hlt), .state_o(st));

  fetch_exec_sequencer #(.MAX_BYTES(2), .EXEC_STEP_W(3)) u_dut2 (
    .clk(clk), .reset(rst_n), .instr_len_i(2'd3), .exec_steps_i(3'd1),
    .is_halt_i(1'b0), .load_mar_pc_o(mar2), .mem_read_o(rd2), .load_ir_o(ir2),
    .load_temp1_o(t12), .load_temp2_o(t22), .pc_inc_o(inc2),
    .exec_valid_o(ev2), .exec_step_o(step2), .halted_o(hlt2), .state_o(st2));

  // Expected observation for a state code, byte index and execute step.
  function automatic obs_t exp_of(int s, int b, int k);
    obs_t o;
    o.st   = 3'(s);
    o.mar  = (s == 1);
    o.rd   = (s == 2);
    o.ir   = (s == 3) && (b == 0);
    o.t1   = (s == 3) && (b == 1);
    o.t2   = (s == 3) && (b == 2);
    o.inc  = (s == 4);
    o.ev   = (s == 5);
    o.step = (s == 5) ? 3'(k) : 3'd0;
    o.halt = (s == 6);
    return o;
  endfunction

  // Called at posedge+1: reset low for 'hold' cycles, plus the idle cycle
  // after release; returns at posedge+1 of the first F_ADDR.
  task automatic reset_seq(input int hold);
    rst_n = 1'b0;
    for (int i = 0; i < hold + 1; i++) expq.push_back(exp_of(0, 0, 0));
    repeat (hold) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // abort_at: -1 = run to completion, -2 = random abort point,
  // otherwise reset is asserted during trace cycle abort_at.
  task automatic run_instr(input int l, input int s, input bit h, input int abort_at);
    obs_t tr[$];
    int   nb, ns, ab;
    len = 2'(l); steps = 3'(s); halt = h;
    nb = h ? 1 : ((l == 0) ? 1 : l);
    ns = (s == 0) ? 1 : s;
    for (int b = 0; b < nb; b++)
      for (int p = 1; p <= 4; p++) tr.push_back(exp_of(p, b, 0));
    if (h) for (int i = 0; i < 20; i++) tr.push_back(exp_of(6, 0, 0));
    else   for (int k = 0; k < ns; k++) tr.push_back(exp_of(5, 0, k));
    ab = abort_at;
    if (ab == -2) ab = int'($urandom_range(1, tr.size() - 1));
    if (ab < 0 || ab >= tr.size()) begin
      foreach (tr[i]) expq.push_back(tr[i]);
      repeat (tr.size()) @(posedge clk);
      #1;
      if (h) reset_seq(2);
    end else begin
      for (int i = 0; i < ab; i++) expq.push_back(tr[i]);
      repeat (ab) @(posedge clk);
      #1;
      reset_seq(2);
    end
  endtask

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      obs_t e, a;
      e = expq.pop_front();
      a = obs_t'({st, mar, rd, ir, t1, t2, inc, ev, step, hlt});
      n_cmp++;
      if (a !== e) begin
        n_err++;
        $display("FAIL seq cyc=%0d got=%h exp=%h", cyc_no, a, e);
      end
      cyc_no++;
    end
  end

  // MAX_BYTES=2 instance: 3-byte opcode clamps to 2 bytes, 1 exec step,
  // giving a 9-cycle period after the idle reset cycle; temp_2 never loads.
  always @(negedge clk) begin
    int es;
    if (rst_n === 1'b0) begin
      c2 = 0;
      n_cmp++;
      if ({st2, t22} !== 4'b0000) begin
        n_err++;
        $display("FAIL clamp_rst got=%0d/%0b exp=0/0", st2, t22);
      end
    end else if (rst_n === 1'b1 && $time > 5) begin
      if (c2 == 0) es = 0;
      else if ((c2 - 1) % 9 == 8) es = 5;
      else es = ((c2 - 1) % 9) % 4 + 1;
      n_cmp++;
      if ({st2, t22} !== {3'(es), 1'b0}) begin
        n_err++;
        $display("FAIL clamp c2=%0d got=%0d/%0b exp=%0d/0", c2, st2, t22, es);
      end
      c2++;
    end
  end

  initial begin
    rst_n = 1'b1; len = 2'd1; steps = 3'd1; halt = 1'b0;
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    reset_seq(3);
    run_instr(2, 1, 1'b0, -1);   // LDI_A
    run_instr(2, 2, 1'b0, -1);   // ORI
    run_instr(1, 1, 1'b1, -1);   // HLT, then reset
    run_instr(3, 1, 1'b0, -1);   // 3-byte opcode
    run_instr(0, 1, 1'b0, -1);   // length 0 -> one byte
    run_instr(1, 0, 1'b0, -1);   // zero steps -> one EXEC cycle
    run_instr(1, 7, 1'b0, -1);   // full 7-step window
    run_instr(2, 2, 1'b0, 5);    // reset during F_READ of byte 1
    run_instr(2, 2, 1'b0, 9);    // reset during EXEC step 1
    for (int i = 0; i < 40; i++)
      run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 7) == 0) ? -2 : -1);
    repeat (2) @(posedge clk);
    n_cmp++;
    if (expq.size() != 0) begin
      n_err++;
      $display("FAIL drain left=%0d exp=0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_exec_sequencer.md
Name: fetch_exec_sequencer

Overview:
Sequences the SAP-2 CPU datapath through fetch, multi-byte operand fetch, execute and halt. Drives the one-hot strobes that load MAR from PC, read memory, latch IR/temp_1/temp_2 and increment PC. Hands a bounded execute window to the per-opcode microcode. Sits inside the CPU beside the opcode decoder, replacing the ad-hoc step counter in the control unit.

Parameters:
MAX_BYTES, 3, max instruction length in bytes (opcode + operands)
EXEC_STEP_W, 3, width of execute-step counter; max execute window 2^EXEC_STEP_W-1 cycles

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
instr_len_i  input  2  byte count for latched opcode from decoder (valid while IR holds opcode)
exec_steps_i  input  EXEC_STEP_W  execute cycles needed by latched opcode
is_halt_i  input  1  decoder flag: latched opcode is HLT
load_mar_pc_o  output  1  MAR <= PC this cycle
mem_read_o  output  1  memory read enable (sync ROM/RAM, data valid next cycle)
load_ir_o  output  1  IR <= mem data
load_temp1_o  output  1  temp_1 <= mem data
load_temp2_o  output  1  temp_2 <= mem data
pc_inc_o  output  1  PC <= PC+1
exec_valid_o  output  1  execute window active
exec_step_o  output  EXEC_STEP_W  current execute step, 0-based
halted_o  output  1  sequencer in HALT
state_o  output  3  encoded state for debug/bench

Behaviour:
- States: S_RESET(0), F_ADDR(1), F_READ(2), F_LATCH(3), F_INC(4), EXEC(5), HALT(6).
- Reset asserted (low), any state, mid-instruction included: state=S_RESET immediately; all strobes 0, exec_step_o=0, byte_idx=0, halted_o=0.
- S_RESET -> F_ADDR on first clock after release; one idle cycle.
- Every byte fetch is exactly 4 cycles: F_ADDR (load_mar_pc_o=1) -> F_READ (mem_read_o=1) -> F_LATCH (exactly one of load_ir/temp1/temp2 =1 per byte_idx 0/1/2) -> F_INC (pc_inc_o=1).
- byte_idx 0-based, increments in F_INC; target register selected by byte_idx.
- instr_len_i and is_halt_i sampled in F_INC of byte 0 into internal len_q; exec_steps_i sampled in last F_INC.
- F_INC exits, in priority order: byte 0 and is_halt_i=1 -> HALT (halted_o=1 from next cycle; HLT is 1 byte, PC already incremented); byte_idx+1 < len_q -> F_ADDR; else -> EXEC.
- len_q: instr_len_i=0 treated as 1; values > MAX_BYTES clamp to MAX_BYTES.
- EXEC: exec_valid_o=1, exec_step_o counts 0..N-1, N = exec_steps_i (0 treated as 1). After step N-1 -> F_ADDR, byte_idx=0, exec_step_o=0.
- Counter width rule: exec_step_o never wraps; terminal compare on N-1.
- HALT: absorbing; all strobes 0, exec_valid_o=0; only reset exits.
- Outputs registered-state decodes (Moore); no strobe asserted in two states; at most one load_* per cycle.
- Latency: n-byte, N-step instruction takes 4n+N cycles from F_ADDR of byte 0 to next F_ADDR.

Test Plan:
- Release reset -> state_o 0 for 1 cycle, then F_ADDR; first load_ir_o on cycle 3 after release; all strobes 0 while reset low.
- LDI_A (len 2, steps 1): load_ir_o cycle 3, load_temp1_o cycle 7, exec_valid_o cycle 9 only, F_ADDR cycle 10; pc_inc_o pulses twice.
- ORI (len 2, steps 2) then HLT: exec_step_o 0,1 on consecutive cycles; next opcode fetched; HLT -> halted_o=1 after its F_INC, strobes stay 0 for 20 cycles, total pc_inc_o pulses = 5.
- 3-byte opcode (len 3): load_ir, load_temp1, load_temp2 each pulse once, 4 cycles apart; instr_len_i=0 -> single-byte fetch; instr_len_i=3 with MAX_BYTES=2 -> 2 bytes.
- exec_steps_i=0 -> exactly one EXEC cycle; exec_steps_i=7 -> exec_step_o 0..6 then F_ADDR, no wrap.
- Assert reset during F_READ of byte 1 and during EXEC step 1 -> same cycle all strobes 0, state_o 0; after release fetch restarts at byte 0 (load_ir_o first).
